// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable glitch-free clock divider; divisor changes take effect only on a period wrap.
// Define CLK_DIV_TICK_EN to add tick_out, a one-cycle pulse following each wrap edge.
module clk_div_prog #(
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 500000
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
`ifdef CLK_DIV_TICK_EN
    output logic             tick_out,
`endif
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] n, cnt, pend;
    logic [CNT_W:0]   h, cnt_inc;
    logic             wrap, load_ok, load_bad;

    // High-phase length ceil(N/2); one extra bit keeps N = 2^CNT_W-1 from overflowing.
    assign h        = ({1'b0, n} + (CNT_W+1)'(1)) >> 1;
    assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    assign wrap     = cnt == n - CNT_W'(1);
    assign load_ok  = div_load && div_val >= CNT_W'(2);
    assign load_bad = div_load && div_val < CNT_W'(2);

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            n        <= DEF_N;
            cnt      <= DEF_N - CNT_W'(1);
            pend     <= '0;
            div_busy <= 1'b0;
            div_err  <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            div_err <= load_bad;
            if (en) begin
                cnt     <= wrap ? '0 : cnt_inc[CNT_W-1:0];
                clk_out <= wrap || cnt_inc < h;
                if (wrap && div_busy)
                    n <= pend;
            end
            // A load on the wrap edge wins over the clear, so it waits for the next wrap.
            if (load_ok) begin
                pend     <= div_val;
                div_busy <= 1'b1;
            end else if (en && wrap) begin
                div_busy <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_TICK_EN
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst)
            tick_out <= 1'b0;
        else
            tick_out <= en && wrap;
    end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and random checks of clk_div_prog against a waveform-queue reference model.
module tb_clk_div_prog;

    logic       clk_50MHz = 1'b0;
    logic       rst, en, div_load;
    logic [7:0] div_val;
    logic       div_busy, div_err, clk_out;
`ifdef CLK_DIV_TICK_EN
    logic       tick_out;
`endif

    clk_div_prog #(.CNT_W(8), .DEF_DIV(10)) dut (
        .clk_50MHz(clk_50MHz),
        .rst(rst),
        .en(en),
        .div_val(div_val),
        .div_load(div_load),
        .div_busy(div_busy),
        .div_err(div_err),
`ifdef CLK_DIV_TICK_EN
        .tick_out(tick_out),
`endif
        .clk_out(clk_out)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Model: each period is a queued list of output levels built from N when the previous one runs out.
    logic q[$];
    int   m_n, m_pend, n_assert, n_fail;
    logic m_busy, m_clk, m_err, m_tick;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("clk_out", clk_out, m_clk);
        chk("div_busy", div_busy, m_busy);
        chk("div_err", div_err, m_err);
`ifdef CLK_DIV_TICK_EN
        chk("tick_out", tick_out, m_tick);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_n = 10; m_pend = 0; m_busy = 0; m_clk = 0; m_err = 0; m_tick = 0;
    endtask

    task automatic step(input logic e, input logic ld, input logic [7:0] v);
        en = e; div_load = ld; div_val = v;
        @(posedge clk_50MHz);
        m_tick = 0;
        if (e) begin
            if (q.size() == 0) begin
                if (m_busy) begin
                    m_n = m_pend;
                    m_busy = 0;
                end
                for (int i = 0; i < m_n; i++) q.push_back(i < (m_n + 1) / 2);
                m_tick = 1;
            end
            m_clk = q.pop_front();
        end
        m_err = ld && v < 2;
        if (ld && v >= 2) begin
            m_pend = v;
            m_busy = 1;
        end
        #1;
        check_all();
        div_load = 0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0);
    endtask

    task automatic to_wrap();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1, 0, 0);
        chk("reach_wrap", q.size() == 0, 1'b1);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 0; en = 0; div_load = 0; div_val = 0;
        model_reset();
        #100;
        check_all();
        rst = 1;
        run(30);
        // Load 7 mid-period, then watch several 7-cycle periods.
        run(3);
        step(1, 1, 7);
        run(30);
        // Rejected divisors.
        run(2);
        step(1, 1, 1);
        run(3);
        step(1, 1, 0);
        run(15);
        // Two loads in one period: last one wins.
        step(1, 1, 6);
        step(1, 1, 4);
        run(20);
        // Load coincident with a wrap is deferred one period.
        to_wrap();
        step(1, 1, 12);
        run(40);
        // Freeze during the high phase.
        to_wrap();
        run(2);
        for (int i = 0; i < 13; i++) step(0, 0, 0);
        run(30);
        // Async reset with a pending load.
        run(3);
        step(1, 1, 5);
        rst = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk_50MHz);
        #1;
        check_all();
        rst = 1;
        run(25);
        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 8'($urandom_range(0, 15)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
